// File: rtl/robot_pkg.sv
// Shared types and default constants for the knight-move sequencer datapath.
package robot_pkg;

    localparam int unsigned FRWRD_W = 10;
    localparam int unsigned ERR_W   = 12;
    localparam int unsigned DIST_W  = 3;
    localparam int unsigned CNT_W   = 4;

    localparam logic [FRWRD_W-1:0] FRWRD_INC  = 10'h010;
    localparam logic [FRWRD_W-1:0] MAX_SPD    = 10'h300;
    localparam logic [ERR_W-1:0]   ERR_THRESH = 12'h030;

    typedef enum logic [2:0] {IDLE, SETTLE, RAMP_UP, DECEL, DONE} mv_state_t;

    // |err| < ERR_THRESH on a signed value; the most negative code never settles.
    function automatic logic err_settled(input logic [ERR_W-1:0] err);
        logic [ERR_W-1:0] mag;
        mag = err[ERR_W-1] ? ERR_W'(-err) : err;
        return (err != {1'b1, {(ERR_W-1){1'b0}}}) && (mag < ERR_THRESH);
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Command/sensor inputs and PID-facing outputs of the move sequencer.
interface move_sequencer_if;
    import robot_pkg::*;

    logic                 cmd_vld;
    logic [DIST_W-1:0]    cmd_dist;
    logic [ERR_W-1:0]     error;
    logic                 err_vld;
    logic                 heading_rdy;
    logic                 cntrIR;
    logic                 moving;
    logic [FRWRD_W-1:0]   frwrd;
    logic                 busy;
    logic                 move_done;

    modport slave (
        input  cmd_vld, cmd_dist, error, err_vld, heading_rdy, cntrIR,
        output moving, frwrd, busy, move_done
    );

    modport master (
        output cmd_vld, cmd_dist, error, err_vld, heading_rdy, cntrIR,
        input  moving, frwrd, busy, move_done
    );

endinterface

// File: rtl/frwrd_ramp.sv
// Forward-speed register: saturating ramp-up, flooring double-step ramp-down.
module frwrd_ramp
    import robot_pkg::*;
#(
    parameter logic [FRWRD_W-1:0] INC = FRWRD_INC,
    parameter logic [FRWRD_W-1:0] MAX = MAX_SPD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [FRWRD_W-1:0] o_frwrd
);

    logic [FRWRD_W-1:0] r_frwrd;
    logic [FRWRD_W:0]   w_sum;
    logic [FRWRD_W:0]   w_dec_step;

    // One extra bit so the increment can be compared against MAX without wrapping.
    assign w_sum      = {1'b0, r_frwrd} + {1'b0, INC};
    assign w_dec_step = {INC, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frwrd <= '0;
        end else if (i_clr) begin
            r_frwrd <= '0;
        end else if (i_inc) begin
            r_frwrd <= (w_sum > {1'b0, MAX}) ? MAX : w_sum[FRWRD_W-1:0];
        end else if (i_dec) begin
            r_frwrd <= ({1'b0, r_frwrd} <= w_dec_step) ? '0
                                                      : FRWRD_W'({1'b0, r_frwrd} - w_dec_step);
        end
    end

    assign o_frwrd = r_frwrd;

endmodule

// File: rtl/move_sequencer.sv
// Sequences settle, ramp-up/cruise, line counting and ramp-down for one move leg.
module move_sequencer
    import robot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    move_sequencer_if.slave   bus
);

    mv_state_t          r_state;
    mv_state_t          w_next;
    logic [DIST_W-1:0]  r_dist;
    logic [CNT_W-1:0]   r_line_cnt;
    logic               r_cntr_ff;
    logic               r_moving;
    logic               r_busy;
    logic               r_move_done;

    logic               w_edge;
    logic               w_latch;
    logic               w_inc;
    logic               w_dec;
    logic               w_clr;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_target;
    logic [FRWRD_W-1:0] w_frwrd;

    assign w_edge   = bus.cntrIR & ~r_cntr_ff;
    // Two line edges per square: entry and exit of each line.
    assign w_target = CNT_W'({r_dist, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_inc    = 1'b0;
        w_dec    = 1'b0;
        w_clr    = 1'b0;
        w_cnt_en = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (bus.cmd_vld) begin
                    w_latch = 1'b1;
                    w_next  = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.err_vld && err_settled(bus.error)) begin
                    w_next = (r_dist == '0) ? DECEL : RAMP_UP;
                end
            end
            RAMP_UP: begin
                w_inc    = bus.heading_rdy;
                w_cnt_en = w_edge;
                if (r_line_cnt == w_target) begin
                    w_next = DECEL;
                end
            end
            DECEL: begin
                w_dec    = bus.heading_rdy;
                w_cnt_en = w_edge;
                if (w_frwrd == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_clr  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Command latch, line counter, edge detect and Moore outputs from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dist      <= '0;
            r_line_cnt  <= '0;
            r_cntr_ff   <= 1'b0;
            r_moving    <= 1'b0;
            r_busy      <= 1'b0;
            r_move_done <= 1'b0;
        end else begin
            r_cntr_ff <= bus.cntrIR;
            if (w_latch) begin
                r_dist     <= bus.cmd_dist;
                r_line_cnt <= '0;
            end else if (w_cnt_en) begin
                r_line_cnt <= r_line_cnt + CNT_W'(1);
            end
            r_moving    <= (w_next == SETTLE) || (w_next == RAMP_UP) || (w_next == DECEL);
            r_busy      <= (w_next != IDLE);
            r_move_done <= (w_next == DONE);
        end
    end

    frwrd_ramp #(
        .INC (FRWRD_INC),
        .MAX (MAX_SPD)
    ) u_frwrd_ramp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_frwrd (w_frwrd)
    );

    assign bus.frwrd     = w_frwrd;
    assign bus.moving    = r_moving;
    assign bus.busy      = r_busy;
    assign bus.move_done = r_move_done;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: expected frwrd steps and done pulses are queued by stimulus.
module tb_move_sequencer;
    import robot_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    move_sequencer_if bus();

    move_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] q_frwrd[$];
    logic       q_done[$];
    logic [9:0] m_frwrd = 10'h000;
    logic [9:0] prev_frwrd = 10'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every change of frwrd and every move_done pulse consumes a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frwrd !== prev_frwrd) begin
                if (q_frwrd.size() == 0)
                    chk("frwrd_unexpected", 32'(bus.frwrd), 32'(prev_frwrd));
                else
                    chk("frwrd_seq", 32'(bus.frwrd), 32'(q_frwrd.pop_front()));
            end
            if (bus.move_done) begin
                if (q_done.size() == 0) begin
                    chk("done_unexpected", 32'(bus.move_done), 32'h0);
                end else begin
                    chk("done_moving", 32'(bus.moving), 32'(q_done.pop_front()));
                    chk("done_frwrd", 32'(bus.frwrd), 32'h0);
                end
            end
        end
        prev_frwrd = bus.frwrd;
    end

    task automatic hr_up();
        logic [10:0] s;
        s = 11'(m_frwrd) + 11'h010;
        if (s > 11'h300) s = 11'h300;
        if (10'(s) != m_frwrd) q_frwrd.push_back(10'(s));
        m_frwrd = 10'(s);
        bus.heading_rdy = 1'b1;
        @(negedge clk);
        bus.heading_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic hr_dn();
        logic [9:0] nv;
        nv = (m_frwrd <= 10'h020) ? 10'h000 : m_frwrd - 10'h020;
        if (nv != m_frwrd) q_frwrd.push_back(nv);
        m_frwrd = nv;
        bus.heading_rdy = 1'b1;
        @(negedge clk);
        bus.heading_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic line_edge();
        bus.cntrIR = 1'b1;
        @(negedge clk);
        bus.cntrIR = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [2:0] d);
        bus.cmd_vld  = 1'b1;
        bus.cmd_dist = d;
        @(negedge clk);
        bus.cmd_vld  = 1'b0;
    endtask

    task automatic send_err(input logic [11:0] e);
        bus.err_vld = 1'b1;
        bus.error   = e;
        @(negedge clk);
        bus.err_vld = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.move_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_vld     = 1'b0;
        bus.cmd_dist    = 3'd0;
        bus.error       = 12'h000;
        bus.err_vld     = 1'b0;
        bus.heading_rdy = 1'b0;
        bus.cntrIR      = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_frwrd", 32'(bus.frwrd), 32'h0);
        chk("rst_moving", 32'(bus.moving), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.move_done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Move 1: dist=1, unsettled error first, short ramp, two line edges.
        q_done.push_back(1'b0);
        send_cmd(3'd1);
        chk("cmd_moving", 32'(bus.moving), 32'h1);
        chk("cmd_busy", 32'(bus.busy), 32'h1);
        send_err(12'h100);
        chk("settle_hold_moving", 32'(bus.moving), 32'h1);
        bus.heading_rdy = 1'b1;
        @(negedge clk);
        bus.heading_rdy = 1'b0;
        @(negedge clk);
        chk("settle_hold_frwrd", 32'(bus.frwrd), 32'h0);
        send_err(12'hFF0);
        repeat (3) hr_up();
        line_edge();
        line_edge();
        repeat (2) hr_dn();
        wait_done();
        chk("done_busy_high", 32'(bus.busy), 32'h1);
        @(negedge clk);
        chk("after_done_busy", 32'(bus.busy), 32'h0);
        chk("after_done_moving", 32'(bus.moving), 32'h0);

        // Move 2: dist=2, saturate at cruise, ignored cmd in RAMP_UP and in DONE.
        q_done.push_back(1'b0);
        send_cmd(3'd2);
        send_err(12'h000);
        repeat (20) hr_up();
        bus.cmd_vld  = 1'b1;
        bus.cmd_dist = 3'd7;
        @(negedge clk);
        bus.cmd_vld  = 1'b0;
        repeat (40) hr_up();
        chk("sat_frwrd", 32'(bus.frwrd), 32'h300);
        repeat (4) line_edge();
        chk("decel_entry_frwrd", 32'(bus.frwrd), 32'h300);
        repeat (24) hr_dn();
        wait_done();
        bus.cmd_vld  = 1'b1;
        bus.cmd_dist = 3'd5;
        @(negedge clk);
        bus.cmd_vld  = 1'b0;
        chk("done_cmd_moving", 32'(bus.moving), 32'h0);
        chk("done_cmd_busy", 32'(bus.busy), 32'h0);
        repeat (3) @(negedge clk);
        chk("no_second_move", 32'(bus.moving), 32'h0);

        // Move 3: dist=0 goes straight through DECEL with frwrd held at zero.
        q_done.push_back(1'b0);
        send_cmd(3'd0);
        send_err(12'h000);
        wait_done();
        @(negedge clk);
        chk("zero_dist_busy", 32'(bus.busy), 32'h0);

        // Move 4: async reset in the middle of the ramp.
        send_cmd(3'd3);
        send_err(12'h000);
        repeat (10) hr_up();
        chk("pre_reset_frwrd", 32'(bus.frwrd), 32'h0A0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_frwrd", 32'(bus.frwrd), 32'h0);
        chk("abort_moving", 32'(bus.moving), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        m_frwrd = 10'h000;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_moving", 32'(bus.moving), 32'h0);

        chk("frwrd_queue_empty", 32'(q_frwrd.size()), 32'h0);
        chk("done_queue_empty", 32'(q_done.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Sequences the PID heading/speed datapath for one knight-move leg.
- On a command, it asserts moving and waits for the heading error to settle. It then ramps frwrd up to a cruise speed and counts line crossings from the IR sensor. After the commanded number of squares it ramps frwrd back down to zero and pulses move_done.
- Sits between the command processor and the PID block; it drives the PID's moving and frwrd inputs.

Parameters:
- FRWRD_INC, 10'h010, frwrd step per heading_rdy during ramp-up; ramp-down step is 2*FRWRD_INC.
- MAX_SPD, 10'h300, cruise ceiling for frwrd.
- ERR_THRESH, 12'h030, settle window; the settle test is |error| < ERR_THRESH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- cmd_vld  in  1  1-cycle start strobe; sampled only in IDLE
- cmd_dist  in  3  squares to travel, 0..7
- error  in  12  signed heading error (same as the PID input)
- err_vld  in  1  error-valid strobe
- heading_rdy  in  1  gyro-update strobe; paces the ramps
- cntrIR  in  1  line-sensor level; each rising edge is one line crossing
- moving  out  1  drives the PID moving input
- frwrd  out  10  unsigned forward speed to the PID
- busy  out  1  high in every state except IDLE
- move_done  out  1  1-cycle pulse at the end of the move

Behaviour:
- Reset (async, rst_n low): state=IDLE, frwrd=0, moving=0, busy=0, move_done=0, line count=0, dist register=0, cntrIR edge-detect flop=0. Reset mid-move aborts immediately to these values.
- Inputs are registered as needed for edge detection only; state and outputs are flopped (outputs are Moore-style, from state/register).
- Move completes when line count == 2*dist.
- IDLE:
  - moving=0, frwrd=0.
  - cmd_vld=1: latch cmd_dist, clear line count, go to SETTLE next cycle.
  - cmd_vld in any other state is ignored.
- SETTLE:
  - moving=1, frwrd=0.
  - The first err_vld cycle with |error| < ERR_THRESH goes to RAMP_UP; if dist==0, it goes to DECEL instead.
  - |error| is computed on a 12-bit signed value; -2048 counts as not settled.
- RAMP_UP (also cruise):
  - moving=1.
  - On each heading_rdy, frwrd <= min(frwrd+FRWRD_INC, MAX_SPD). Compute with 11 bits to avoid wrap; frwrd never exceeds MAX_SPD.
  - A cntrIR rising edge (cntrIR & ~cntrIR_ff) increments the 4-bit line count.
  - When line count reaches 2*dist (two edges per square, entry and exit of the line), go to DECEL. The check is made on the updated count, so the transition happens the cycle after the edge.
- DECEL:
  - moving=1.
  - On each heading_rdy, frwrd <= (frwrd <= 2*FRWRD_INC) ? 0 : frwrd-2*FRWRD_INC. Floors at 0, no underflow.
  - Line edges are still counted but ignored.
  - When frwrd==0 at a heading_rdy, or on entry with frwrd==0: go to DONE.
- DONE:
  - moving=0, frwrd=0, move_done=1 for exactly one cycle, then IDLE.
  - busy=0 in DONE is not required; busy deasserts in IDLE.
  - A cmd_vld arriving in the DONE cycle is ignored.
- Simultaneous heading_rdy and line edge in RAMP_UP: both take effect in the same cycle; the ramp step applies and the count increments.
- Latency:
  - cmd_vld to moving=1: 1 cycle.
  - Settled err_vld to the first frwrd increment: first heading_rdy after entering RAMP_UP.

Decomposition:
- A shared package (robot_pkg) holds:
  - typedef enum logic [2:0] {IDLE, SETTLE, RAMP_UP, DECEL, DONE} mv_state_t;
  - the default constants FRWRD_INC, MAX_SPD and ERR_THRESH.
- One natural sub-module, frwrd_ramp: the frwrd register with inc/dec/clr controls and saturating/flooring arithmetic. The FSM, line counter and edge detect stay in move_sequencer.

Test Plan:
- Reset mid-RAMP_UP (frwrd=0x0A0, rst_n low) -> same-cycle frwrd=0, moving=0, busy=0, state IDLE.
- cmd_vld with cmd_dist=1; error=0x100 on err_vld, then error=-0x010 on err_vld -> stays in SETTLE with frwrd=0 until the second strobe; then frwrd steps 0x010, 0x020, ... per heading_rdy.
- Ramp with 60 heading_rdy strobes and no line edges -> frwrd saturates at 0x300 and holds; never 0x310 or a wrapped value.
- cmd_dist=2 at cruise, 4 cntrIR rising edges -> DECEL after the 4th edge; frwrd steps down by 0x020 per heading_rdy to 0; move_done is a single pulse; busy falls the next cycle.
- cmd_dist=0 -> SETTLE, then DECEL, then DONE; frwrd stays 0 throughout; move_done pulses once.
- cmd_vld during RAMP_UP and during DONE -> ignored: latched dist and line count unchanged, no second move.
